// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Definitions shared by the walk/sensor conditioner and the traffic light
//   controller: the walk request FSM state encoding and the default cycle
//   counts derived from the 100 MHz system clock. The controller's seconds
//   divider reuses CLK_HZ.
//   No ports (package).
package traffic_pkg;

  // Walk request FSM states. The encoding is visible on req_state for debug.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    SERVING = 2'b10,
    LOCKOUT = 2'b11
  } walk_state_t;

  localparam int CLK_HZ          = 100_000_000;
  localparam int DEB_DEFAULT     = CLK_HZ / 100;  // 10 ms button debounce
  localparam int QUAL_DEFAULT    = CLK_HZ / 2;    // 0.5 s sensor qualification
  localparam int LOCKOUT_DEFAULT = CLK_HZ * 2;    // 2 s post-service press ignore

endpackage

// File: rtl/sync_debounce.sv
// sync_debounce
//   Brings one asynchronous raw input into the clk domain through a
//   SYNC_STAGES flop chain, then holds a filtered level that only changes
//   after the synchronized input has disagreed with it for N consecutive
//   cycles. Rise and fall are filtered identically.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (all state clears to 0)
//   din   - raw input, asynchronous to clk
//   dout  - filtered level, registered
module sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int N           = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int            CW   = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt;

  assign synced = sync_q[SYNC_STAGES-1];

  // The counter tracks how long synced has disagreed with dout. It tops out
  // at N-1: on that edge, if the disagreement persists, dout takes the new
  // level and the counter restarts, so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      dout   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (synced == dout) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        dout <= synced;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/walk_sensor_conditioner.sv
// walk_sensor_conditioner
//   Input conditioning in front of the traffic light controller. The
//   pedestrian button and the vehicle sensor are synchronized and filtered;
//   each accepted button press latches a walk request that is held until the
//   controller has shown its walk lamp.
//   Optional build macro WALK_LOCKOUT_EN adds a LOCKOUT state after service
//   during which new presses are ignored for LOCKOUT_CYCLES clocks.
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   WalkButton - raw pedestrian button (asynchronous)
//   Sensor     - raw vehicle sensor (asynchronous)
//   walk_ack   - controller WalkLamp level, high during the walk phase
//   walk_req   - latched walk request level (high only in PENDING)
//   walk_pulse - one-clk pulse per accepted press (debug/LED)
//   sensor_q   - qualified vehicle presence level
//   req_state  - walk FSM state encoding (debug)
//
// Request handshake: walk_req is a level that rises when a press is
// accepted and stays high until walk_ack is seen high; it drops on the same
// edge that SERVING is entered. The request is complete when walk_ack falls.
// walk_ack seen high while no request is outstanding is ignored.
module walk_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DEB_CYCLES     = DEB_DEFAULT,
  parameter int QUAL_CYCLES    = QUAL_DEFAULT,
  parameter int LOCKOUT_CYCLES = LOCKOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       WalkButton,
  input  logic       Sensor,
  input  logic       walk_ack,
  output logic       walk_req,
  output logic       walk_pulse,
  output logic       sensor_q,
  output logic [1:0] req_state
);

  // Cycles the debounced button must sit low before presses are accepted.
  // Covers the full sync + debounce latency, so a button held through reset
  // rises before arming completes and is never taken as a press.
  localparam int ARM_LIMIT = SYNC_STAGES + DEB_CYCLES;
  localparam int AW        = $clog2(ARM_LIMIT + 1);

  logic          btn_deb;
  logic          btn_deb_q;
  logic          armed;
  logic [AW-1:0] arm_cnt;
  logic          press;
  walk_state_t   state_q;
  walk_state_t   state_d;
  logic          rearm_q;
  logic          rearm_d;

  sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .N          (DEB_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (WalkButton),
    .dout (btn_deb)
  );

  sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .N          (QUAL_CYCLES)
  ) u_sensor (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (Sensor),
    .dout (sensor_q)
  );

  // Accepted press: rising edge of the debounced button, once armed.
  assign press = btn_deb & ~btn_deb_q & armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_deb_q  <= 1'b0;
      walk_pulse <= 1'b0;
      armed      <= 1'b0;
      arm_cnt    <= '0;
    end else begin
      btn_deb_q  <= btn_deb;
      walk_pulse <= press;
      if (btn_deb) begin
        arm_cnt <= '0;
      end else if (!armed) begin
        if (arm_cnt == AW'(ARM_LIMIT)) begin
          armed <= 1'b1;
        end else begin
          arm_cnt <= arm_cnt + 1'b1;
        end
      end
    end
  end

`ifdef WALK_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  logic [LW-1:0] lock_cnt;
  logic          lock_done;

  // Runs only while in LOCKOUT; the final count is the LOCKOUT_CYCLES-th
  // cycle spent there.
  assign lock_done = (lock_cnt == LW'(LOCKOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if (state_q != LOCKOUT) begin
      lock_cnt <= '0;
    end else begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rearm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rearm_q <= rearm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rearm_d = rearm_q;
    case (state_q)
      PENDING: begin
        // Repeat presses are absorbed; the request is already latched.
        if (walk_ack) state_d = SERVING;
      end
      SERVING: begin
        if (press) rearm_d = 1'b1;
        if (!walk_ack) begin
          // A press that lands on the same cycle as the ack fall still counts.
          if (rearm_q || press) begin
            state_d = PENDING;
            rearm_d = 1'b0;
          end else begin
`ifdef WALK_LOCKOUT_EN
            state_d = LOCKOUT;
`else
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef WALK_LOCKOUT_EN
      LOCKOUT: begin
        if (lock_done) state_d = IDLE;
      end
`endif
      // IDLE, and the unused 11 encoding when lockout is not built.
      default: begin
        if (press) state_d = PENDING;
      end
    endcase
  end

  assign walk_req  = (state_q == PENDING);
  assign req_state = state_q;

endmodule

// File: tb/tb_walk_sensor_conditioner.sv
// tb_walk_sensor_conditioner
//   Directed bench for walk_sensor_conditioner with SYNC_STAGES=2,
//   DEB_CYCLES=4, QUAL_CYCLES=8, LOCKOUT_CYCLES=16. Stimulus pushes the
//   expected output snapshot for a future cycle into exp_q; the monitor
//   compares when that cycle is sampled. Every walk_pulse seen must match
//   an entry in pulse_q. The lockout scenario runs when WALK_LOCKOUT_EN is
//   defined.
module tb_walk_sensor_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int QUAL = 8;
  localparam int LOCK = 16;

`ifdef WALK_LOCKOUT_EN
  localparam logic [1:0] ST_AFTER = 2'b11;
`else
  localparam logic [1:0] ST_AFTER = 2'b00;
`endif

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       WalkButton = 1'b0;
  logic       Sensor     = 1'b0;
  logic       walk_ack   = 1'b0;
  logic       walk_req;
  logic       walk_pulse;
  logic       sensor_q;
  logic [1:0] req_state;

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;

  // {target cycle[31:0], walk_req, sensor_q, req_state[1:0], walk_pulse}
  logic [36:0] exp_q[$];
  string       name_q[$];
  int          pulse_q[$];

  walk_sensor_conditioner #(
    .SYNC_STAGES   (SYNC),
    .DEB_CYCLES    (DEB),
    .QUAL_CYCLES   (QUAL),
    .LOCKOUT_CYCLES(LOCK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .WalkButton(WalkButton),
    .Sensor    (Sensor),
    .walk_ack  (walk_ack),
    .walk_req  (walk_req),
    .walk_pulse(walk_pulse),
    .sensor_q  (sensor_q),
    .req_state (req_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  // Advance n rising edges, then settle 2 time units past the edge. Inputs
  // change at these points; cyc then equals the number of edges so far.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Expected outputs as sampled d edges from now.
  task automatic expect_at(input int d, input logic req, input logic sq,
                           input logic [1:0] st, input logic pl, input string nm);
    exp_q.push_back({32'(cyc + d), req, sq, st, pl});
    name_q.push_back(nm);
  endtask

  task automatic expect_pulse(input int d);
    pulse_q.push_back(cyc + d);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [4:0] act;
    logic [4:0] ex;
    int         tgt;
    string      nm;
    act = {walk_req, sensor_q, req_state, walk_pulse};
    while (exp_q.size() > 0 && int'(exp_q[0][36:5]) <= cyc) begin
      tgt = int'(exp_q[0][36:5]);
      ex  = exp_q[0][4:0];
      nm  = name_q[0];
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
      vectors++;
      if (tgt != cyc) begin
        miscompares++;
        $display("FAIL %s: check for cycle %0d not sampled (now cycle %0d)", nm, tgt, cyc);
      end else if (act !== ex) begin
        miscompares++;
        $display("FAIL %s @%0d: got {req,sq,st,pulse}=%b, want %b", nm, cyc, act, ex);
      end
    end
    while (pulse_q.size() > 0 && pulse_q[0] < cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL pulse_missing: expected walk_pulse at cycle %0d, got no walk_pulse", pulse_q[0]);
      void'(pulse_q.pop_front());
    end
    if (walk_pulse !== 1'b0) begin
      vectors++;
      if (pulse_q.size() > 0 && pulse_q[0] == cyc) begin
        void'(pulse_q.pop_front());
      end else begin
        miscompares++;
        $display("FAIL pulse_unexpected @%0d: got walk_pulse=%b, want 0", cyc, walk_pulse);
      end
    end
  end

  // ---------------- final report ----------------
  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  initial begin : watchdog
    #50000;
    miscompares++;
    $display("FAIL watchdog: bench did not complete, got cycle %0d, want < 5000", cyc);
    report();
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    // Reset, then let the press arming window elapse.
    tick(3);
    expect_at(0, 1'b0, 1'b0, 2'b00, 1'b0, "reset_state");
    rst_n = 1'b1;
    tick(12);
    expect_at(0, 1'b0, 1'b0, 2'b00, 1'b0, "idle_after_reset");

    // Button bounce: 2-clk toggles for 20 clk produce nothing.
    for (int i = 0; i < 10; i++) begin
      WalkButton = (i % 2 == 0);
      tick(2);
    end
    expect_at(0, 1'b0, 1'b0, 2'b00, 1'b0, "idle_after_bounce");
    WalkButton = 1'b1;
    expect_at(6, 1'b0, 1'b0, 2'b00, 1'b0, "press_not_yet");
    expect_at(7, 1'b1, 1'b0, 2'b01, 1'b1, "press_accepted");
    expect_pulse(7);
    expect_at(8, 1'b1, 1'b0, 2'b01, 1'b0, "pulse_one_clk");
    tick(10);

    // Service handshake; button stays held (no new press).
    walk_ack = 1'b1;
    expect_at(0, 1'b1, 1'b0, 2'b01, 1'b0, "pending_at_ack");
    expect_at(1, 1'b0, 1'b0, 2'b10, 1'b0, "serving_req_drop");
    tick(10);
    walk_ack = 1'b0;
    expect_at(0, 1'b0, 1'b0, 2'b10, 1'b0, "serving_held");
    expect_at(1, 1'b0, 1'b0, ST_AFTER, 1'b0, "service_done");
    tick(2);
    WalkButton = 1'b0;
    tick(22);

    // Rearm: press accepted during SERVING returns to PENDING on ack fall.
    expect_at(0, 1'b0, 1'b0, 2'b00, 1'b0, "idle_before_rearm");
    WalkButton = 1'b1;
    expect_pulse(7);
    expect_at(7, 1'b1, 1'b0, 2'b01, 1'b1, "second_press");
    tick(9);
    walk_ack = 1'b1;
    tick(1);
    WalkButton = 1'b0;
    tick(8);
    WalkButton = 1'b1;
    expect_pulse(7);
    expect_at(7, 1'b0, 1'b0, 2'b10, 1'b1, "press_in_serving");
    tick(10);
    walk_ack = 1'b0;
    expect_at(1, 1'b1, 1'b0, 2'b01, 1'b0, "rearm_pending");
    tick(3);
    walk_ack = 1'b1;
    expect_at(1, 1'b0, 1'b0, 2'b10, 1'b0, "rearm_serving");
    tick(2);
    walk_ack   = 1'b0;
    WalkButton = 1'b0;
    expect_at(1, 1'b0, 1'b0, ST_AFTER, 1'b0, "rearm_done");
    tick(25);

    // Sensor: 7-clk blip is rejected; 9-clk high qualifies at edge 10.
    Sensor = 1'b1;
    tick(7);
    Sensor = 1'b0;
    expect_at(3, 1'b0, 1'b0, 2'b00, 1'b0, "sensor_blip_a");
    expect_at(6, 1'b0, 1'b0, 2'b00, 1'b0, "sensor_blip_b");
    tick(8);
    Sensor = 1'b1;
    expect_at(9, 1'b0, 1'b0, 2'b00, 1'b0, "sensor_not_yet");
    expect_at(10, 1'b0, 1'b1, 2'b00, 1'b0, "sensor_qualified");
    tick(9);
    Sensor = 1'b0;
    expect_at(9, 1'b0, 1'b1, 2'b00, 1'b0, "sensor_fall_not_yet");
    expect_at(10, 1'b0, 1'b0, 2'b00, 1'b0, "sensor_fall");
    tick(15);

    // Reset mid-request: async clear, held button is not a new press.
    Sensor = 1'b1;
    tick(3);
    WalkButton = 1'b1;
    expect_pulse(7);
    tick(8);
    expect_at(0, 1'b1, 1'b1, 2'b01, 1'b0, "pending_before_reset");
    tick(1);
    rst_n  = 1'b0;
    Sensor = 1'b0;
    expect_at(0, 1'b0, 1'b0, 2'b00, 1'b0, "async_reset");
    tick(1);
    rst_n = 1'b1;
    expect_at(8, 1'b0, 1'b0, 2'b00, 1'b0, "held_after_reset_a");
    expect_at(15, 1'b0, 1'b0, 2'b00, 1'b0, "held_after_reset_b");
    tick(17);
    WalkButton = 1'b0;
    tick(16);
    WalkButton = 1'b1;
    expect_pulse(7);
    expect_at(7, 1'b1, 1'b0, 2'b01, 1'b1, "press_after_reset");
    tick(10);

`ifdef WALK_LOCKOUT_EN
    // Lockout: presses within 16 clk of ack fall pulse but do not request.
    walk_ack = 1'b1;
    tick(1);
    WalkButton = 1'b0;
    tick(2);
    walk_ack = 1'b0;
    expect_at(1, 1'b0, 1'b0, 2'b11, 1'b0, "lockout_entered");
    tick(5);
    WalkButton = 1'b1;
    expect_pulse(7);
    expect_at(7, 1'b0, 1'b0, 2'b11, 1'b1, "lockout_press_ignored");
    tick(8);
    WalkButton = 1'b0;
    expect_at(3, 1'b0, 1'b0, 2'b11, 1'b0, "lockout_last_cycle");
    expect_at(4, 1'b0, 1'b0, 2'b00, 1'b0, "lockout_expired");
    tick(8);
    WalkButton = 1'b1;
    expect_pulse(7);
    expect_at(7, 1'b1, 1'b0, 2'b01, 1'b1, "press_after_lockout");
    tick(10);
`endif

    tick(5);
    while (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: check for cycle %0d never sampled", name_q[0], int'(exp_q[0][36:5]));
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end
    while (pulse_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pulse_missing: expected walk_pulse at cycle %0d, got no walk_pulse", pulse_q[0]);
      void'(pulse_q.pop_front());
    end
    report();
  end

endmodule
